// File: rtl/rp_pio_err_pkg.sv
// Shared constants and helpers for the RP PIO error log: the register address map,
// the pointer layout and the mapping from a field index to its register bit.
package rp_pio_err_pkg;

  localparam int unsigned ADDR_W        = 4;
  localparam int unsigned PTR_IDX_W     = 5;
  localparam int unsigned PTR_VALID_BIT = 31;

  localparam logic [ADDR_W-1:0] ADDR_STATUS = 4'd0;
  localparam logic [ADDR_W-1:0] ADDR_MASK   = 4'd1;
  localparam logic [ADDR_W-1:0] ADDR_SEV    = 4'd2;
  localparam logic [ADDR_W-1:0] ADDR_PTR    = 4'd3;
  localparam logic [ADDR_W-1:0] ADDR_HDR0   = 4'd4;

  // Field f = s*ncauses + c lives at register bit s*stride + c.
  function automatic int unsigned field_bit(input int unsigned idx,
                                            input int unsigned ncauses,
                                            input int unsigned stride);
    return (idx / ncauses) * stride + (idx % ncauses);
  endfunction

endpackage

// File: rtl/rp_pio_prio_enc.sv
// Lowest-index-wins priority encoder; picks the first-error field among
// simultaneous unmasked events.
module rp_pio_prio_enc #(
  parameter int unsigned W     = 9,
  parameter int unsigned IDX_W = 5
) (
  input  logic [W-1:0]     req_i,
  output logic             valid_o,
  output logic [IDX_W-1:0] idx_o
);

  // Scan from the top so the lowest set bit is the last one written.
  always_comb begin
    idx_o = '0;
    for (int i = W - 1; i >= 0; i--) begin
      if (req_i[i]) idx_o = IDX_W'(i);
    end
  end

  assign valid_o = |req_i;

endmodule

// File: rtl/rp_pio_err_log.sv
// RP PIO error log: per-space/per-cause RW1CS status with mask and severity,
// first-error pointer with TLP header log, and registered interrupt outputs.
module rp_pio_err_log
  import rp_pio_err_pkg::*;
#(
  parameter int unsigned NUM_SPACES   = 3,
  parameter int unsigned NUM_CAUSES   = 3,
  parameter int unsigned SPACE_STRIDE = 8,
  parameter int unsigned HDR_WORDS    = 4,
  parameter logic [31:0] MASK_RST     = 32'h0007_0707,
  localparam int unsigned NF          = NUM_SPACES * NUM_CAUSES
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NF-1:0]           evt_set,
  input  logic [32*HDR_WORDS-1:0] evt_hdr,
  input  logic                    wr_en,
  input  logic                    rd_en,
  input  logic [ADDR_W-1:0]       addr,
  input  logic [31:0]             wr_data,
  output logic [31:0]             rd_data,
  output logic                    irq_fatal,
  output logic                    irq_nonfatal,
  output logic                    err_pulse,
  output logic                    err_pulse_fatal
);

  if (NUM_CAUSES > SPACE_STRIDE) begin : g_chk_stride
    $fatal(1, "NUM_CAUSES must not exceed SPACE_STRIDE");
  end
  if (NUM_SPACES * SPACE_STRIDE > 32) begin : g_chk_width
    $fatal(1, "NUM_SPACES*SPACE_STRIDE must fit in 32 bits");
  end
  if (NF > 32) begin : g_chk_nf
    $fatal(1, "NF must not exceed 32");
  end
  if (ADDR_HDR0 + HDR_WORDS > 16) begin : g_chk_hdr
    $fatal(1, "header log does not fit the address space");
  end

  logic [NF-1:0]                   status_q, status_d, mask_q, mask_d, sev_q, sev_d;
  logic                            ptr_valid_q, ptr_valid_d;
  logic [PTR_IDX_W-1:0]            ptr_idx_q, ptr_idx_d;
  logic [HDR_WORDS-1:0][31:0]      hdr_q, hdr_d;
  logic [31:0]                     rd_data_q, rd_mux;
  logic                            irq_fatal_q, irq_nonfatal_q, err_pulse_q, err_pulse_fatal_q;

  logic [NF-1:0]        wr_f, mask_rst_f, clr_f, unmasked_evt, new_f;
  logic [31:0]          status_r, mask_r, sev_r;
  logic                 status_wr, mask_wr, sev_wr, ptr_clr_hit, capture;
  logic                 enc_valid;
  logic [PTR_IDX_W-1:0] enc_idx;
  logic                 unused_wr;

  assign unused_wr = ^wr_data;

  for (genvar f = 0; f < NF; f++) begin : g_fld
    localparam int unsigned B = field_bit(f, NUM_CAUSES, SPACE_STRIDE);
    assign wr_f[f]       = wr_data[B];
    assign mask_rst_f[f] = MASK_RST[B];
  end

  // Unmapped bit positions are RsvdZ and always read as zero.
  for (genvar b = 0; b < 32; b++) begin : g_bit
    if ((b / SPACE_STRIDE) < NUM_SPACES && (b % SPACE_STRIDE) < NUM_CAUSES) begin : g_map
      localparam int unsigned F = (b / SPACE_STRIDE) * NUM_CAUSES + (b % SPACE_STRIDE);
      assign status_r[b] = status_q[F];
      assign mask_r[b]   = mask_q[F];
      assign sev_r[b]    = sev_q[F];
    end else begin : g_rsvd
      assign status_r[b] = 1'b0;
      assign mask_r[b]   = 1'b0;
      assign sev_r[b]    = 1'b0;
    end
  end

  rp_pio_prio_enc #(.W(NF), .IDX_W(PTR_IDX_W)) u_prio_enc (
    .req_i   (unmasked_evt),
    .valid_o (enc_valid),
    .idx_o   (enc_idx)
  );

  always_comb begin
    status_wr    = wr_en && (addr == ADDR_STATUS);
    mask_wr      = wr_en && (addr == ADDR_MASK);
    sev_wr       = wr_en && (addr == ADDR_SEV);
    clr_f        = status_wr ? wr_f : '0;
    status_d     = (status_q & ~clr_f) | evt_set;
    mask_d       = mask_wr ? wr_f : mask_q;
    sev_d        = sev_wr ? wr_f : sev_q;
    unmasked_evt = evt_set & ~mask_q;
    new_f        = unmasked_evt & ~status_q;

    ptr_clr_hit = 1'b0;
    for (int unsigned f = 0; f < NF; f++) begin
      if (ptr_idx_q == PTR_IDX_W'(f)) ptr_clr_hit = clr_f[f];
    end

    // A clearing write on the pointed-to field reopens capture in the same cycle.
    capture     = enc_valid && (!ptr_valid_q || ptr_clr_hit);
    ptr_valid_d = ptr_valid_q;
    ptr_idx_d   = ptr_idx_q;
    hdr_d       = hdr_q;
    if (capture) begin
      ptr_valid_d = 1'b1;
      ptr_idx_d   = enc_idx;
      hdr_d       = evt_hdr;
    end else if (ptr_valid_q && ptr_clr_hit) begin
      ptr_valid_d = 1'b0;
    end

    rd_mux = '0;
    case (addr)
      ADDR_STATUS: rd_mux = status_r;
      ADDR_MASK:   rd_mux = mask_r;
      ADDR_SEV:    rd_mux = sev_r;
      ADDR_PTR: begin
        rd_mux[PTR_VALID_BIT]   = ptr_valid_q;
        rd_mux[PTR_IDX_W-1:0]   = ptr_idx_q;
      end
      default: begin
        for (int unsigned w = 0; w < HDR_WORDS; w++) begin
          if (addr == ADDR_W'(ADDR_HDR0 + w)) rd_mux = hdr_q[w];
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      status_q          <= '0;
      mask_q            <= mask_rst_f;
      sev_q             <= '0;
      ptr_valid_q       <= 1'b0;
      ptr_idx_q         <= '0;
      hdr_q             <= '0;
      rd_data_q         <= '0;
      irq_fatal_q       <= 1'b0;
      irq_nonfatal_q    <= 1'b0;
      err_pulse_q       <= 1'b0;
      err_pulse_fatal_q <= 1'b0;
    end else begin
      status_q          <= status_d;
      mask_q            <= mask_d;
      sev_q             <= sev_d;
      ptr_valid_q       <= ptr_valid_d;
      ptr_idx_q         <= ptr_idx_d;
      hdr_q             <= hdr_d;
      if (rd_en) rd_data_q <= rd_mux;
      irq_fatal_q       <= |(status_d & ~mask_d & sev_d);
      irq_nonfatal_q    <= |(status_d & ~mask_d & ~sev_d);
      err_pulse_q       <= |new_f;
      err_pulse_fatal_q <= |(new_f & sev_q);
    end
  end

  assign rd_data         = rd_data_q;
  assign irq_fatal       = irq_fatal_q;
  assign irq_nonfatal    = irq_nonfatal_q;
  assign err_pulse       = err_pulse_q;
  assign err_pulse_fatal = err_pulse_fatal_q;

endmodule

// File: tb/tb_rp_pio_err_log.sv
// Directed bench for rp_pio_err_log: register map, event capture, first-error
// pointer, interrupt levels and new-error pulse with hand-computed expectations.
module tb_rp_pio_err_log;

  localparam int unsigned NF = 9;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [NF-1:0] evt_set = '0;
  logic [127:0]  evt_hdr = '0;
  logic          wr_en = 1'b0;
  logic          rd_en = 1'b0;
  logic [3:0]    addr = '0;
  logic [31:0]   wr_data = '0;
  logic [31:0]   rd_data;
  logic          irq_fatal, irq_nonfatal, err_pulse, err_pulse_fatal;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  rp_pio_err_log dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .evt_set         (evt_set),
    .evt_hdr         (evt_hdr),
    .wr_en           (wr_en),
    .rd_en           (rd_en),
    .addr            (addr),
    .wr_data         (wr_data),
    .rd_data         (rd_data),
    .irq_fatal       (irq_fatal),
    .irq_nonfatal    (irq_nonfatal),
    .err_pulse       (err_pulse),
    .err_pulse_fatal (err_pulse_fatal)
  );

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    wr_en = 1'b1; addr = a; wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input logic [3:0] a, input logic [31:0] exp);
    exp_q.push_back(exp);
    rd_en = 1'b1; addr = a;
    tick();
    rd_en = 1'b0;
    chk(tag, rd_data, exp_q.pop_front());
  endtask

  task automatic chk_outs(input string tag, input logic [3:0] exp);
    chk(tag, {28'd0, irq_fatal, irq_nonfatal, err_pulse, err_pulse_fatal}, {28'd0, exp});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset and register map defaults
    rst_n = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    chk_outs("rst_outs", 4'b0000);
    chk("rst_rd_data", rd_data, 32'h0);
    for (int a = 0; a < 16; a++) begin
      rd_chk($sformatf("rst_rd%0d", a), 4'(a), (a == 1) ? 32'h0007_0707 : 32'h0);
    end

    // Unmask all, make mem_cto fatal, then fire it
    wr(4'd1, 32'h0);
    wr(4'd2, 32'h0004_0000);
    rd_chk("mask_zero", 4'd1, 32'h0);
    rd_chk("sev_wr", 4'd2, 32'h0004_0000);
    evt_set = 9'h100;
    evt_hdr = {32'h0000_0003, 32'h0000_0002, 32'h0000_0001, 32'hDEAD_0001};
    tick();
    evt_set = '0;
    chk_outs("evt8_outs", 4'b1011);
    tick();
    chk_outs("evt8_pulse_end", 4'b1000);
    rd_chk("evt8_status", 4'd0, 32'h0004_0000);
    rd_chk("evt8_ptr", 4'd3, 32'h8000_0008);
    rd_chk("evt8_log0", 4'd4, 32'hDEAD_0001);
    rd_chk("evt8_log1", 4'd5, 32'h0000_0001);
    rd_chk("evt8_log3", 4'd7, 32'h0000_0003);

    // Second, non-fatal error while pointer frozen
    evt_set = 9'h001;
    evt_hdr = {96'h0, 32'hBEEF_0002};
    tick();
    evt_set = '0;
    chk_outs("evt0_outs", 4'b1110);
    rd_chk("evt0_status", 4'd0, 32'h0004_0001);
    rd_chk("evt0_ptr", 4'd3, 32'h8000_0008);
    rd_chk("evt0_log0", 4'd4, 32'hDEAD_0001);

    // Clear of the pointed field coincides with a new event on it: set wins
    wr_en = 1'b1; addr = 4'd0; wr_data = 32'h0004_0000;
    evt_set = 9'h100;
    evt_hdr = {96'h0, 32'hCAFE_0003};
    tick();
    wr_en = 1'b0; evt_set = '0;
    chk_outs("setclr_outs", 4'b1100);
    rd_chk("setclr_status", 4'd0, 32'h0004_0001);
    rd_chk("setclr_ptr", 4'd3, 32'h8000_0008);
    rd_chk("setclr_log0", 4'd4, 32'hCAFE_0003);

    // Clear everything, pointer invalidates
    wr(4'd0, 32'h0004_0001);
    chk_outs("clr_all_outs", 4'b0000);
    rd_chk("clr_all_status", 4'd0, 32'h0);
    rd_en = 1'b1; addr = 4'd3;
    tick();
    rd_en = 1'b0;
    chk("clr_all_ptr_valid", {31'd0, rd_data[31]}, 32'h0);

    // Two simultaneous events: lowest index wins
    evt_set = 9'b000000110;
    evt_hdr = {96'h0, 32'h1111_0004};
    tick();
    evt_set = '0;
    chk_outs("dual_outs", 4'b0110);
    rd_chk("dual_status", 4'd0, 32'h0000_0006);
    rd_chk("dual_ptr", 4'd3, 32'h8000_0001);
    rd_chk("dual_log0", 4'd4, 32'h1111_0004);

    // Full mask: event still sets status but nothing else
    wr(4'd0, 32'h0000_0006);
    wr(4'd1, 32'hFFFF_FFFF);
    rd_chk("mask_rsvdz", 4'd1, 32'h0007_0707);
    evt_set = 9'h010;
    evt_hdr = {96'h0, 32'h2222_0005};
    tick();
    evt_set = '0;
    chk_outs("masked_outs", 4'b0000);
    rd_chk("masked_status", 4'd0, 32'h0000_0200);
    rd_en = 1'b1; addr = 4'd3;
    tick();
    rd_en = 1'b0;
    chk("masked_ptr_valid", {31'd0, rd_data[31]}, 32'h0);
    wr(4'd0, 32'h0000_0200);
    rd_chk("masked_clr", 4'd0, 32'h0);

    // Same-cycle write and read returns pre-write contents, then holds
    rd_en = 1'b1; wr_en = 1'b1; addr = 4'd2; wr_data = 32'h0000_0001;
    tick();
    rd_en = 1'b0; wr_en = 1'b0;
    chk("rw_same_cycle", rd_data, 32'h0004_0000);
    tick();
    chk("rd_hold", rd_data, 32'h0004_0000);
    rd_chk("sev_after_wr", 4'd2, 32'h0000_0001);

    // Reset mid-operation drops the event in the reset cycle
    rst_n = 1'b0;
    evt_set = 9'h001;
    tick();
    rst_n = 1'b1; evt_set = '0;
    chk_outs("midrst_outs", 4'b0000);
    rd_chk("midrst_status", 4'd0, 32'h0);
    rd_chk("midrst_mask", 4'd1, 32'h0007_0707);
    rd_chk("midrst_sev", 4'd2, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
